// File: rtl/spi_packet_encoder_if.sv
// Request and SPI bus bundle for spi_packet_encoder.
// slave: the encoder side (takes requests, drives SPI and status).
// master: the requester side (drives requests, observes SPI and status).
interface spi_packet_encoder_if;
    logic       updateConfig;
    logic       brush;
    logic [2:0] newColor;
    logic       updatePosition;
    logic [7:0] x;
    logic [7:0] y;
    logic       sck;
    logic       mosi;
    logic       cs_n;
    logic       busy;
    logic       full;
    logic       dropped;

    modport slave (
        input  updateConfig, brush, newColor, updatePosition, x, y,
        output sck, mosi, cs_n, busy, full, dropped
    );

    modport master (
        output updateConfig, brush, newColor, updatePosition, x, y,
        input  sck, mosi, cs_n, busy, full, dropped
    );
endinterface

// File: rtl/spi_packet_encoder.sv
// spi_packet_encoder: encodes configuration/position updates into two-byte
// packets, queues them in a small FIFO and shifts them out as a mode-0 SPI
// master (MSB first, SCK idles low, data stable before each rising edge).
// All SPI outputs are registered from the current FSM state, so they trail
// the state register by one clock.
// Optional feature: define SPI_TX_STATS_EN to add packetCount/dropCount.
module spi_packet_encoder #(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_packet_encoder_if.slave  bus
`ifdef SPI_TX_STATS_EN
    ,
    output logic [15:0]          packetCount,
    output logic [7:0]           dropCount
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_q [DEPTH];
    logic            sck_q, sck_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;
    logic            dropped_q, dropped_d;

    logic            pop;
    logic            phase_end;
    logic            active;
    logic [15:0]     cfg_pkt;
    logic [15:0]     pos_pkt;
    logic            pos_legal;
    logic [CW-1:0]   space;
    logic            cfg_acc;
    logic            pos_acc;
    logic            wr0_en;
    logic            wr1_en;
    logic [15:0]     wr0_data;
    logic [AW-1:0]   wr_ptr_nx;

    // Request acceptance: config claims the first free slot, position the next.
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        cfg_pkt   = {3'b111, bus.brush, 1'b0, bus.newColor, 8'h00};
        pos_pkt   = {bus.x, bus.y};
        // x[7:5] == 111 would be decoded downstream as a configuration packet.
        pos_legal = (bus.x[7:5] != 3'b111);
        space     = CW'(DEPTH) - count_q + CW'(pop);
        cfg_acc   = bus.updateConfig && (space != '0);
        pos_acc   = bus.updatePosition && pos_legal && (space > CW'(cfg_acc));
        dropped_d = (bus.updateConfig && !cfg_acc) || (bus.updatePosition && !pos_acc);
        wr0_en    = cfg_acc || pos_acc;
        wr1_en    = cfg_acc && pos_acc;
        wr0_data  = cfg_acc ? cfg_pkt : pos_pkt;
        wr_ptr_nx = wr_ptr_q + AW'(1);
        wr_ptr_d  = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q - CW'(pop) + CW'(cfg_acc) + CW'(pos_acc);
    end

    // Next-state logic: IDLE pops, SETUP presents bit 15, HIGH/LOW toggle SCK
    // for 16 bits, GAP guarantees a minimum CS-high time between packets.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        phase_end = (phase_q == PHASE_LAST);
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    phase_d = '0;
                    // Falling SCK edge: advance to the next bit.
                    shreg_d = {shreg_q[14:0], 1'b0};
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    phase_d = '0;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 4'd15) ? S_GAP : S_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                phase_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // SPI pin values derived from the current state; mosi is forced low
    // whenever chip select is released.
    always_comb begin
        active = (state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW);
        cs_n_d = !active;
        sck_d  = (state_q == S_HIGH);
        mosi_d = active && shreg_q[15];
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            dropped_q <= dropped_d;
        end
    end

    // Data storage: FIFO entries and shift register carry no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        if (wr0_en) begin
            mem_q[wr_ptr_q] <= wr0_data;
        end
        if (wr1_en) begin
            mem_q[wr_ptr_nx] <= pos_pkt;
        end
    end

    assign bus.sck     = sck_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = (count_q != '0) || (state_q != S_IDLE);
    assign bus.full    = (count_q == CW'(DEPTH));
    assign bus.dropped = dropped_q;

`ifdef SPI_TX_STATS_EN
    logic [15:0] packet_count_q, packet_count_d;
    logic [7:0]  drop_count_q, drop_count_d;

    // Statistics: packets counted on GAP entry, drops once per pulsing cycle.
    always_comb begin
        packet_count_d = packet_count_q + 16'((state_d == S_GAP) && (state_q != S_GAP));
        drop_count_d   = drop_count_q + 8'(dropped_d);
    end

    // Statistic counters, wrapping on overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            packet_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            packet_count_q <= packet_count_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign packetCount = packet_count_q;
    assign dropCount   = drop_count_q;
`endif

endmodule
